instruction_decode_stage: RTL and testbench

//  Pipelined, parametrised successor to the combinational opcode decoder.

---
 rtl/instruction_decode_stage.sv | 178 +++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
// Pipelined instruction decoder between fetch and execute.
// Decodes each accepted word into ALU/memory/control strobes and holds the
// result for one cycle of latency behind a valid/ready output. It also
// squashes wrong-path words after a branch/jump, can halt on an illegal
// opcode, and counts the legal instructions it emits.
//
// Handshake: a word transfers on a rising edge where valid & ready are both 1.
// valid may not wait for ready, and a held valid keeps its payload stable.
// Each side may take one word per cycle.
module instruction_decode_stage #(
    parameter int INSTR_W         = 16,
    parameter int OPCODE_W        = 8,
    parameter int ALU_CTRL_W      = 4,
    parameter int SHADOW_SLOTS    = 1,
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int CNT_W           = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [INSTR_W-1:0]          instr,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [ALU_CTRL_W-1:0]       alu_ctrl,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic                        reg_write,
    output logic                        branch,
    output logic                        jump,
    output logic                        illegal,
    output logic [INSTR_W-OPCODE_W-1:0] operand,
    output logic [CNT_W-1:0]            dec_count,
    output logic                        halted
);

    localparam int SH_W = (SHADOW_SLOTS > 0) ? $clog2(SHADOW_SLOTS + 1) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SHADOW = 2'd1,
        S_HALT   = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [SH_W-1:0]   shadow_cnt, shadow_nx;

    logic [OPCODE_W-1:0]   opcode;
    logic                  upper_zero;
    logic [ALU_CTRL_W-1:0] d_alu;
    logic                  d_mem_read, d_mem_write, d_reg_write;
    logic                  d_branch, d_jump, d_illegal;
    logic                  accept, load;

    assign opcode     = instr[OPCODE_W-1:0];
    // Opcode bits above bit 7 must be zero for any table entry to match.
    assign upper_zero = ((opcode >> 8) == '0);

    // Opcode lookup; anything outside the table is illegal with no strobes.
    always_comb begin
        d_alu       = '0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_illegal   = 1'b0;
        if (!upper_zero) begin
            d_illegal = 1'b1;
        end else begin
            case (opcode[7:0])
                8'h00: ;
                8'h01: begin d_alu = ALU_CTRL_W'(1); d_reg_write = 1'b1; end
                8'h02: begin d_alu = ALU_CTRL_W'(2); d_reg_write = 1'b1; end
                8'h04: begin d_alu = ALU_CTRL_W'(3); d_reg_write = 1'b1; end
                8'h05: begin d_alu = ALU_CTRL_W'(4); d_reg_write = 1'b1; end
                8'h08: begin d_mem_read = 1'b1; d_reg_write = 1'b1; end
                8'h09: d_mem_write = 1'b1;
                8'h10: d_branch = 1'b1;
                8'h11: d_jump = 1'b1;
                default: d_illegal = 1'b1;
            endcase
        end
    end

    // Input ready: backpressure in RUN, free drain in SHADOW, closed in HALT or flush.
    always_comb begin
        instr_ready = 1'b0;
        case (state)
            S_RUN:    instr_ready = !dec_valid || dec_ready;
            S_SHADOW: instr_ready = 1'b1;
            default:  instr_ready = 1'b0;
        endcase
        if (flush) instr_ready = 1'b0;
    end

    assign accept = instr_valid && instr_ready;
    assign load   = accept && (state == S_RUN);
    assign halted = (state == S_HALT);

    // Next-state and shadow counter; flush overrides everything.
    always_comb begin
        state_nx  = state;
        shadow_nx = shadow_cnt;
        if (flush) begin
            state_nx  = S_RUN;
            shadow_nx = '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (load) begin
                        if ((d_branch || d_jump) && (SHADOW_SLOTS > 0)) begin
                            state_nx  = S_SHADOW;
                            shadow_nx = SH_W'(SHADOW_SLOTS);
                        end else if (d_illegal && (HALT_ON_ILLEGAL != 0)) begin
                            state_nx = S_HALT;
                        end
                    end
                end
                S_SHADOW: begin
                    if (accept) begin
                        if (shadow_cnt <= SH_W'(1)) begin
                            state_nx  = S_RUN;
                            shadow_nx = '0;
                        end else begin
                            shadow_nx = shadow_cnt - SH_W'(1);
                        end
                    end
                end
                default: state_nx = S_HALT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            shadow_cnt <= '0;
        end else begin
            state      <= state_nx;
            shadow_cnt <= shadow_nx;
        end
    end

    // Output register and legal-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid <= 1'b0;
            alu_ctrl  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            reg_write <= 1'b0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            illegal   <= 1'b0;
            operand   <= '0;
            dec_count <= '0;
        end else if (flush) begin
            dec_valid <= 1'b0;
        end else if (load) begin
            dec_valid <= 1'b1;
            alu_ctrl  <= d_alu;
            mem_read  <= d_mem_read;
            mem_write <= d_mem_write;
            reg_write <= d_reg_write;
            branch    <= d_branch;
            jump      <= d_jump;
            illegal   <= d_illegal;
            operand   <= instr[INSTR_W-1:OPCODE_W];
            if (!d_illegal) dec_count <= dec_count + CNT_W'(1);
        end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: decode table vectors, directed
// handshake/shadow/halt/flush/reset sequences and a random stream, all
// checked against a queue of expected decoded words.
module tb_instruction_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  alu_ctrl;
    logic        mem_read, mem_write, reg_write, branch, jump, illegal;
    logic [7:0]  operand;
    logic [15:0] dec_count;
    logic        halted;

    // Second instance with a 2-bit counter to see the wrap.
    logic        instr_ready2, dec_valid2;
    logic [3:0]  alu_ctrl2;
    logic        mem_read2, mem_write2, reg_write2, branch2, jump2, illegal2;
    logic [7:0]  operand2;
    logic [1:0]  dec_count2;
    logic        halted2;

    instruction_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .alu_ctrl(alu_ctrl), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .branch(branch), .jump(jump), .illegal(illegal),
        .operand(operand), .dec_count(dec_count), .halted(halted)
    );

    instruction_decode_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready2), .instr(instr),
        .dec_valid(dec_valid2), .dec_ready(dec_ready),
        .alu_ctrl(alu_ctrl2), .mem_read(mem_read2), .mem_write(mem_write2),
        .reg_write(reg_write2), .branch(branch2), .jump(jump2), .illegal(illegal2),
        .operand(operand2), .dec_count(dec_count2), .halted(halted2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {operand, alu, mem_read, mem_write, reg_write, branch, jump, illegal}
    logic [17:0] dut_pack;
    assign dut_pack = {operand, alu_ctrl, mem_read, mem_write, reg_write, branch, jump, illegal};

    typedef struct {
        logic [7:0] op;
        logic [3:0] alu;
        logic       mr, mw, rw, br, jp, ill;
    } vec_t;

    vec_t vecs[11];

    logic [17:0] exp_q[$];
    int          m_sh;
    bit          m_halt;
    int          m_cnt;
    int          tests_run;
    int          tests_failed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] exp_of(input logic [15:0] w);
        logic [17:0] r;
        r = {w[15:8], 4'd0, 6'b000001};
        for (int i = 0; i < 11; i++) begin
            if (!vecs[i].ill && vecs[i].op == w[7:0])
                r = {w[15:8], vecs[i].alu, vecs[i].mr, vecs[i].mw, vecs[i].rw,
                     vecs[i].br, vecs[i].jp, 1'b0};
        end
        return r;
    endfunction

    // One clock: check and update the model mid-cycle, then step past the edge.
    task automatic cycle();
        bit          m_valid;
        bit          exp_rdy;
        logic [17:0] e;
        @(negedge clk);
        m_valid = (exp_q.size() != 0);
        exp_rdy = !flush && !m_halt && (m_sh != 0 || !m_valid || dec_ready);
        chk("instr_ready", instr_ready, exp_rdy);
        chk("dec_valid", dec_valid, m_valid);
        chk("halted", halted, m_halt);
        chk("dec_count", dec_count, 16'(m_cnt));
        chk("dec_count_w2", dec_count2, m_cnt % 4);
        if (m_valid && dec_ready) begin
            chk("dec_out", dut_pack, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (flush) begin
            exp_q.delete();
            m_sh   = 0;
            m_halt = 1'b0;
        end else if (instr_valid && exp_rdy) begin
            if (m_sh > 0) begin
                m_sh--;
            end else begin
                e = exp_of(instr);
                exp_q.push_back(e);
                if (!e[0]) m_cnt++;
                if (e[2] || e[1]) m_sh = 1;
                else if (e[0]) m_halt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op);
        instr_valid = v;
        instr       = {8'($urandom_range(0, 255)), op};
    endtask

    logic [17:0] hold;

    initial begin
        vecs[0]  = '{8'h00, 4'd0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{8'h01, 4'd1, 0, 0, 1, 0, 0, 0};
        vecs[2]  = '{8'h02, 4'd2, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{8'h04, 4'd3, 0, 0, 1, 0, 0, 0};
        vecs[4]  = '{8'h05, 4'd4, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{8'h08, 4'd0, 1, 0, 1, 0, 0, 0};
        vecs[6]  = '{8'h09, 4'd0, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{8'h10, 4'd0, 0, 0, 0, 1, 0, 0};
        vecs[8]  = '{8'h11, 4'd0, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{8'h3F, 4'd0, 0, 0, 0, 0, 0, 1};
        vecs[10] = '{8'hFF, 4'd0, 0, 0, 0, 0, 0, 1};

        tests_run = 0; tests_failed = 0;
        m_sh = 0; m_halt = 1'b0; m_cnt = 0;
        rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; instr = '0; dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_fields", dut_pack, 0);
        chk("rst_dec_count", dec_count, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;

        // T1: back-to-back stream
        dec_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, vecs[i].op);
            cycle();
        end
        drive(1'b0, 8'h00);
        cycle(); cycle();
        chk("t1_count", dec_count, 6);
        chk("t1_count_wrap", dec_count2, 2);

        // T2: stall with a waiting word
        drive(1'b1, 8'h01);
        cycle();
        dec_ready = 1'b0;
        drive(1'b1, 8'h02);
        hold = dut_pack;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_stable", dut_pack, hold);
            chk("t2_ready_low", instr_ready, 0);
        end
        dec_ready = 1'b1;
        cycle();
        drive(1'b0, 8'h00);
        cycle(); cycle();

        // T3: branch shadow squashes ADD, SUB follows
        drive(1'b1, 8'h10); cycle();
        drive(1'b1, 8'h01); cycle();
        drive(1'b1, 8'h02); cycle();
        chk("t3_sub_alu", alu_ctrl, 2);
        drive(1'b0, 8'h00); cycle(); cycle();

        // T4: illegal opcode halts until flush
        drive(1'b1, 8'h3F); cycle();
        chk("t4_illegal", illegal, 1);
        chk("t4_halted", halted, 1);
        drive(1'b1, 8'h01);
        repeat (3) cycle();
        drive(1'b0, 8'h00);
        flush = 1'b1; cycle();
        flush = 1'b0;
        chk("t4_run", halted, 0);
        drive(1'b1, 8'h01); cycle();
        drive(1'b0, 8'h00); cycle(); cycle();

        // T5: flush against a full register and a waiting word
        dec_ready = 1'b0;
        drive(1'b1, 8'h01); cycle();
        flush = 1'b1; drive(1'b1, 8'h02); cycle();
        flush = 1'b0; drive(1'b0, 8'h00);
        chk("t5_flushed", dec_valid, 0);
        cycle();
        dec_ready = 1'b1;

        // Decode table, one vector at a time from a clean RUN state
        for (int i = 0; i < 11; i++) begin
            flush = 1'b1; cycle(); flush = 1'b0;
            drive(1'b1, vecs[i].op);
            cycle();
            chk("vec", dut_pack, {instr[15:8], vecs[i].alu, vecs[i].mr, vecs[i].mw,
                                  vecs[i].rw, vecs[i].br, vecs[i].jp, vecs[i].ill});
            drive(1'b0, 8'h00);
            cycle();
        end
        flush = 1'b1; cycle(); flush = 1'b0;

        // Random stream
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, vecs[$urandom_range(0, 10)].op);
            dec_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;

        // T6: asynchronous reset mid-stream
        dec_ready = 1'b0;
        drive(1'b1, 8'h01); cycle(); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_dec_valid", dec_valid, 0);
        chk("t6_fields", dut_pack, 0);
        chk("t6_count", dec_count, 0);
        chk("t6_count_w2", dec_count2, 0);
        chk("t6_halted", halted, 0);
        exp_q.delete(); m_sh = 0; m_halt = 1'b0; m_cnt = 0;
        drive(1'b0, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dec_ready = 1'b1;
        drive(1'b1, 8'h05); cycle();
        drive(1'b0, 8'h00); cycle(); cycle();
        chk("t6_recover_count", dec_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
